dmem_access_ctrl: RTL and testbench

- Sits directly downstream of the MEM stage. Consumes its address, write data, write enable, byte strobe and read enable, and runs one request/response transaction per instruction with the data memory.
- Holds the pipeline stalled until the memory answers, then returns load data to MEM for forwarding to write-back.
- Adds a response timeout and a word-alignment check so a hung or misused bus never deadlocks the core.

---
 rtl/dmem_access_ctrl_if.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 141 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Request/response bus between the data-memory access controller and the data memory.
// The master side issues requests and consumes responses; the slave side is the memory.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_data;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Runs one data-memory transaction per MEM-stage instruction, stalling the core until the
// memory answers, with a response timeout and a word-alignment guard.
module dmem_access_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ALIGN_CHECK    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_write_data_i,
    input  logic                mem_wen_i,
    input  logic [DATA_W/8-1:0] mem_wstrb_i,
    input  logic                mem_ren_i,
    dmem_access_ctrl_if.master  bus,
    output logic                stall_o,
    output logic [DATA_W-1:0]   mem_read_data_o,
    output logic                access_err_o
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_we;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
    logic [CNT_W-1:0]      r_cnt;

    logic w_any;
    logic w_misalign;
    logic w_tmo;
    logic w_req_valid;
    logic w_stall;
    logic w_capture;
    logic w_complete;
    logic w_abort;

    assign w_any      = mem_wen_i || mem_ren_i;
    assign w_misalign = (ALIGN_CHECK != 0) && (&mem_wstrb_i) && (mem_addr_i[1:0] != 2'b00);
    assign w_tmo      = (TIMEOUT_CYCLES != 0) && (r_cnt == TMO_LAST);

    always_comb begin
        w_next      = r_state;
        w_req_valid = 1'b0;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    // Gate with reset so the core is never held while the block is in reset.
                    w_stall   = rst_n;
                    w_capture = 1'b1;
                    w_next    = w_misalign ? DONE : REQ;
                end
            end
            REQ: begin
                w_stall     = 1'b1;
                w_req_valid = !w_tmo;
                if (w_req_valid && bus.req_ready) begin
                    if (bus.rsp_valid) begin
                        w_complete = 1'b1;
                        w_next     = DONE;
                    end else begin
                        w_next = RESP;
                    end
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end
            end
            RESP: begin
                w_stall = 1'b1;
                if (bus.rsp_valid) begin
                    w_complete = 1'b1;
                    w_next     = DONE;
                end else if (w_tmo) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_cnt <= '0;
            end else if ((r_state == REQ || r_state == RESP) && r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // A write+read conflict or a misaligned word access is flagged up front.
            if (w_capture) begin
                r_we    <= mem_wen_i;
                r_addr  <= mem_addr_i;
                r_wdata <= mem_write_data_i;
                r_wstrb <= mem_wen_i ? mem_wstrb_i : '0;
                r_err   <= (mem_wen_i && mem_ren_i) || w_misalign;
                if (w_misalign) r_rdata <= '0;
            end
            if (w_complete) begin
                if (!r_we) r_rdata <= bus.rsp_err ? '0 : bus.rsp_data;
                r_err <= r_err || bus.rsp_err;
            end
            if (w_abort) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign bus.req_valid   = w_req_valid;
    assign bus.req_we      = r_we;
    assign bus.req_addr    = r_addr;
    assign bus.req_wdata   = r_wdata;
    assign bus.req_wstrb   = r_wstrb;
    assign stall_o         = w_stall;
    assign mem_read_data_o = r_rdata;
    assign access_err_o    = (r_state == DONE) && r_err;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: the bench plays the data memory by hand and checks
// every expected value against hand-computed constants.
module tb_dmem_access_ctrl;
    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_write_data_i;
    logic        mem_wen_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_ren_i;
    logic        stall_o;
    logic [31:0] mem_read_data_o;
    logic        access_err_o;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_access_ctrl #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8), .ALIGN_CHECK(1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_addr_i       (mem_addr_i),
        .mem_write_data_i (mem_write_data_i),
        .mem_wen_i        (mem_wen_i),
        .mem_wstrb_i      (mem_wstrb_i),
        .mem_ren_i        (mem_ren_i),
        .bus              (bus),
        .stall_o          (stall_o),
        .mem_read_data_o  (mem_read_data_o),
        .access_err_o     (access_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0;
        mem_addr_i = '0; mem_write_data_i = '0; mem_wen_i = 1'b0;
        mem_wstrb_i = '0; mem_ren_i = 1'b1;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0; bus.rsp_err = 1'b0;
        #3;
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_req_we", bus.req_we, 0);
        chk("rst_req_addr", bus.req_addr, 0);
        chk("rst_req_wdata", bus.req_wdata, 0);
        chk("rst_req_wstrb", bus.req_wstrb, 0);
        chk("rst_rdata", mem_read_data_o, 0);
        chk("rst_err", access_err_o, 0);
        chk("rst_stall", stall_o, 0);
        mem_ren_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Load 0xDEADBEEF from 0x100, zero-wait memory
        mem_ren_i = 1'b1; mem_addr_i = 32'h100; mem_wstrb_i = 4'hF; bus.req_ready = 1'b1;
        #1;
        chk("ld_idle_stall", stall_o, 1);
        chk("ld_idle_valid", bus.req_valid, 0);
        tick();
        chk("ld_req_valid", bus.req_valid, 1);
        chk("ld_req_addr", bus.req_addr, 32'h100);
        chk("ld_req_we", bus.req_we, 0);
        chk("ld_req_wstrb", bus.req_wstrb, 0);
        chk("ld_req_stall", stall_o, 1);
        tick();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_data = 32'hDEADBEEF;
        #1;
        chk("ld_resp_valid", bus.req_valid, 0);
        chk("ld_resp_stall", stall_o, 1);
        tick();
        bus.rsp_valid = 1'b0; mem_ren_i = 1'b0;
        #1;
        chk("ld_done_stall", stall_o, 0);
        chk("ld_done_rdata", mem_read_data_o, 32'hDEADBEEF);
        chk("ld_done_err", access_err_o, 0);
        tick();
        chk("ld_idle_err", access_err_o, 0);

        // Store 0x12345678 to 0x204, ready low for 5 cycles
        mem_wen_i = 1'b1; mem_addr_i = 32'h204; mem_write_data_i = 32'h12345678; mem_wstrb_i = 4'hF;
        #1;
        chk("st_idle_stall", stall_o, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 5) bus.req_ready = 1'b1;
            #1;
            chk("st_req_valid", bus.req_valid, 1);
            chk("st_req_we", bus.req_we, 1);
            chk("st_req_addr", bus.req_addr, 32'h204);
            chk("st_req_wdata", bus.req_wdata, 32'h12345678);
            chk("st_req_wstrb", bus.req_wstrb, 4'hF);
            chk("st_req_stall", stall_o, 1);
        end
        tick();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1;
        #1;
        chk("st_resp_valid", bus.req_valid, 0);
        chk("st_resp_stall", stall_o, 1);
        tick();
        bus.rsp_valid = 1'b0; mem_wen_i = 1'b0;
        #1;
        chk("st_done_stall", stall_o, 0);
        chk("st_done_err", access_err_o, 0);
        chk("st_done_rdata_kept", mem_read_data_o, 32'hDEADBEEF);
        tick();

        // Load returns a bus error, then a back-to-back load completes in the handshake cycle
        mem_ren_i = 1'b1; mem_addr_i = 32'h110; mem_wstrb_i = 4'hF; bus.req_ready = 1'b1;
        tick();
        tick();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_err = 1'b1; bus.rsp_data = 32'hCAFEF00D;
        tick();
        bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0; mem_addr_i = 32'h114;
        #1;
        chk("err_done_rdata", mem_read_data_o, 0);
        chk("err_done_err", access_err_o, 1);
        chk("err_done_stall", stall_o, 0);
        tick();
        #1;
        chk("b2b_idle_err", access_err_o, 0);
        chk("b2b_idle_stall", stall_o, 1);
        tick();
        bus.req_ready = 1'b1; bus.rsp_valid = 1'b1; bus.rsp_data = 32'h5A5AA5A5;
        #1;
        chk("b2b_req_addr", bus.req_addr, 32'h114);
        chk("b2b_req_valid", bus.req_valid, 1);
        tick();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; mem_ren_i = 1'b0;
        #1;
        chk("b2b_done_stall", stall_o, 0);
        chk("b2b_done_rdata", mem_read_data_o, 32'h5A5AA5A5);
        chk("b2b_done_err", access_err_o, 0);
        tick();

        // Misaligned word load from 0x102
        mem_ren_i = 1'b1; mem_addr_i = 32'h102; mem_wstrb_i = 4'hF;
        #1;
        chk("mis_idle_stall", stall_o, 1);
        chk("mis_idle_valid", bus.req_valid, 0);
        tick();
        mem_ren_i = 1'b0;
        #1;
        chk("mis_done_valid", bus.req_valid, 0);
        chk("mis_done_stall", stall_o, 0);
        chk("mis_done_err", access_err_o, 1);
        chk("mis_done_rdata", mem_read_data_o, 0);
        tick();
        chk("mis_idle_err", access_err_o, 0);

        // Timeout: accepted in the first REQ cycle, never answered
        mem_ren_i = 1'b1; mem_addr_i = 32'h300; mem_wstrb_i = 4'hF; bus.req_ready = 1'b1;
        tick();
        chk("tmo_req_valid", bus.req_valid, 1);
        tick();
        bus.req_ready = 1'b0;
        for (int i = 1; i < 8; i++) begin
            if (i > 1) tick();
            #1;
            chk("tmo_resp_stall", stall_o, 1);
            chk("tmo_resp_valid", bus.req_valid, 0);
            chk("tmo_resp_err", access_err_o, 0);
        end
        tick();
        mem_ren_i = 1'b0;
        #1;
        chk("tmo_done_stall", stall_o, 0);
        chk("tmo_done_err", access_err_o, 1);
        chk("tmo_done_rdata", mem_read_data_o, 0);
        chk("tmo_done_valid", bus.req_valid, 0);
        tick();
        chk("tmo_idle_err", access_err_o, 0);

        // Write and read both requested: write wins, error flagged
        mem_wen_i = 1'b1; mem_ren_i = 1'b1; mem_addr_i = 32'h400;
        mem_write_data_i = 32'h11; mem_wstrb_i = 4'b0011; bus.req_ready = 1'b1;
        tick();
        chk("cf_req_we", bus.req_we, 1);
        chk("cf_req_wstrb", bus.req_wstrb, 4'b0011);
        chk("cf_req_wdata", bus.req_wdata, 32'h11);
        tick();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1;
        tick();
        bus.rsp_valid = 1'b0; mem_wen_i = 1'b0; mem_ren_i = 1'b0;
        #1;
        chk("cf_done_err", access_err_o, 1);
        chk("cf_done_stall", stall_o, 0);
        tick();

        // Reset in RESP abandons the load; a late response is ignored
        mem_ren_i = 1'b1; mem_addr_i = 32'h120; mem_wstrb_i = 4'hF; bus.req_ready = 1'b1;
        tick();
        tick();
        bus.req_ready = 1'b0;
        #1;
        chk("rr_resp_stall", stall_o, 1);
        rst_n = 1'b0;
        #1;
        chk("rr_valid", bus.req_valid, 0);
        chk("rr_addr", bus.req_addr, 0);
        chk("rr_we", bus.req_we, 0);
        chk("rr_wdata", bus.req_wdata, 0);
        chk("rr_wstrb", bus.req_wstrb, 0);
        chk("rr_stall", stall_o, 0);
        chk("rr_err", access_err_o, 0);
        mem_ren_i = 1'b0;
        tick();
        rst_n = 1'b1; bus.rsp_valid = 1'b1; bus.rsp_data = 32'h00000BAD;
        tick();
        bus.rsp_valid = 1'b0;
        #1;
        chk("rr_late_stall", stall_o, 0);
        chk("rr_late_valid", bus.req_valid, 0);
        chk("rr_late_rdata", mem_read_data_o, 0);
        chk("rr_late_err", access_err_o, 0);
        mem_ren_i = 1'b1; mem_addr_i = 32'h124; bus.req_ready = 1'b1;
        tick();
        chk("rr_next_addr", bus.req_addr, 32'h124);
        chk("rr_next_valid", bus.req_valid, 1);
        tick();
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b1; bus.rsp_data = 32'h13579BDF;
        tick();
        bus.rsp_valid = 1'b0; mem_ren_i = 1'b0;
        #1;
        chk("rr_next_rdata", mem_read_data_o, 32'h13579BDF);
        chk("rr_next_err", access_err_o, 0);
        chk("rr_next_stall", stall_o, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
